// File: rtl/axi4lite_s_mem.sv
// axi4lite_s_mem: AXI4-Lite slave RAM model with byte strobes and SLVERR on out-of-range words
//
// Parameters: ADDR_W byte-address width, DATA_W 32/64/128, DEPTH words (any value),
//             STALL_CYC ready-deassert cycles after each handshake (stall build only).
// Optional feature macro: AXI4LITE_S_MEM_STALL_EN adds per-channel stall counters.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel (00 OKAY, 10 SLVERR)
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel (00 OKAY, 10 SLVERR)
module axi4lite_s_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int STALL_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IW     = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_q;
  logic [DATA_W-1:0] w_q;
  logic [STRB_W-1:0] s_q;
  logic              aw_hs, w_hs, ar_hs, exec, wr_ok, rd_ok;
  logic              aw_stall, w_stall, ar_stall;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [STRB_W-1:0] ws;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> OFF) < ADDR_W'(DEPTH);
  endfunction
  function automatic logic [IW-1:0] idx(input logic [ADDR_W-1:0] a);
    return IW'(a >> OFF);
  endfunction
`ifdef AXI4LITE_S_MEM_STALL_EN
  localparam int CW = STALL_CYC > 0 ? $clog2(STALL_CYC + 1) : 1;
  logic [CW-1:0] aw_cnt, w_cnt, ar_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aw_cnt <= '0;
      w_cnt  <= '0;
      ar_cnt <= '0;
    end else begin
      aw_cnt <= aw_hs ? CW'(STALL_CYC) : aw_cnt - CW'(aw_cnt != '0);
      w_cnt  <= w_hs  ? CW'(STALL_CYC) : w_cnt  - CW'(w_cnt  != '0);
      ar_cnt <= ar_hs ? CW'(STALL_CYC) : ar_cnt - CW'(ar_cnt != '0);
    end
  assign aw_stall = aw_cnt != '0;
  assign w_stall  = w_cnt  != '0;
  assign ar_stall = ar_cnt != '0;
`else
  logic unused_stall;
  assign unused_stall = ^STALL_CYC;
  assign aw_stall = 1'b0;
  assign w_stall  = 1'b0;
  assign ar_stall = 1'b0;
`endif
  assign awready = !aw_held && !aw_stall;
  assign wready  = !w_held && !w_stall;
  assign arready = (!rvalid || rready) && !ar_stall;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  // A payload arriving this cycle bypasses its holding register so a complete
  // AW+W pair executes on its handshake edge and B appears one cycle later.
  assign wa    = aw_held ? aw_q : awaddr;
  assign wd    = w_held ? w_q : wdata;
  assign ws    = w_held ? s_q : wstrb;
  assign exec  = (aw_held || aw_hs) && (w_held || w_hs) && (!bvalid || bready);
  assign wr_ok = in_range(wa);
  assign rd_ok = in_range(araddr);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      s_q     <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      aw_held <= (aw_held || aw_hs) && !exec;
      w_held  <= (w_held || w_hs) && !exec;
      if (aw_hs) aw_q <= awaddr;
      if (w_hs) begin
        w_q <= wdata;
        s_q <= wstrb;
      end
      if (exec) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? OKAY : SLVERR;
      end else if (bready) bvalid <= 1'b0;
    end
  // Storage is deliberately not reset; the rst term blocks writes while reset is asserted.
  always_ff @(posedge clk)
    if (exec && wr_ok && !rst)
      for (int i = 0; i < STRB_W; i++)
        if (ws[i]) mem[idx(wa)][8*i +: 8] <= wd[8*i +: 8];
  // Nonblocking memory update means a same-edge read sees the pre-write word.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rvalid <= 1'b0;
      rresp  <= OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= rd_ok ? OKAY : SLVERR;
      rdata  <= rd_ok ? mem[idx(araddr)] : '0;
    end else if (rready) rvalid <= 1'b0;
endmodule

// File: tb/tb_axi4lite_s_mem.sv
// tb_axi4lite_s_mem: directed and random AXI4-Lite transactions checked against a word-array reference
module tb_axi4lite_s_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] model [1024];
  int          vecs = 0, errs = 0;
  logic [31:0] old_w;
  logic [31:0] burst [4];

  axi4lite_s_mem dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ok_addr(input logic [31:0] a);
    return (a / 4) < 1024;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ok_addr(a) ? model[a / 4] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ok_addr(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_go, w_go;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      @(negedge clk);
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      n++;
    end
    chk("wr_handshake_timeout", n < 50, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wr_bvalid_latency", bvalid, 1);
    chk("wr_bresp", bresp, ok_addr(a) ? 2'b00 : 2'b10);
    ref_wr(a, d, s);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a);
    logic go;
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      @(negedge clk);
      go = arready;
      @(posedge clk); #1;
      if (go) arvalid = 1'b0;
      n++;
    end
    chk("rd_handshake_timeout", n < 50, 1);
    arvalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_latency", rvalid, 1);
    chk("rd_rdata", rdata, ref_rd(a));
    chk("rd_rresp", rresp, ok_addr(a) ? 2'b00 : 2'b10);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;

    axi_write(32'h10, 32'hDEADBEEF, 4'hF);
    axi_read(32'h10);
    axi_write(32'h10, 32'h11223344, 4'b0101);
    chk("partial_strobe_ref", ref_rd(32'h10), 32'hDE22BE44);
    axi_read(32'h10);

    axi_write(32'h1000, 32'h55AA55AA, 4'hF);
    axi_read(32'h1000);
    axi_read(32'h0);

`ifndef AXI4LITE_S_MEM_STALL_EN
    // W leads AW by three cycles, then B is back-pressured.
    bready = 1'b0;
    awaddr = 32'h40; wdata = 32'hA5A50001; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("wlead_wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("wlead_w_held", wready, 0);
      chk("wlead_no_b", bvalid, 0);
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(negedge clk);
    chk("wlead_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wlead_b_1cyc", bvalid, 1);
    chk("wlead_bresp", bresp, 0);
    ref_wr(32'h40, 32'hA5A50001, 4'hF);
    awaddr = 32'h44; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bstall_awready", awready, 0);
      chk("bstall_wready", wready, 0);
      chk("bstall_bvalid", bvalid, 1);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_reload", bvalid, 1);
    chk("b_reload_awready", awready, 1);
    ref_wr(32'h44, 32'h0BADF00D, 4'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_retired", bvalid, 0);
    @(posedge clk); #1;
    axi_read(32'h40);
    axi_read(32'h44);

    // Four back-to-back reads, one beat per cycle.
    burst[0] = 32'h10; burst[1] = 32'h14; burst[2] = 32'h40; burst[3] = 32'h44;
    araddr = burst[0]; arvalid = 1'b1; rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_arready", arready, 1);
      if (k > 0) begin
        chk("burst_rvalid", rvalid, 1);
        chk("burst_rdata", rdata, ref_rd(burst[k-1]));
      end
      @(posedge clk); #1;
      if (k < 3) araddr = burst[k+1];
      else arvalid = 1'b0;
    end
    @(negedge clk);
    chk("burst_last_rvalid", rvalid, 1);
    chk("burst_last_rdata", rdata, ref_rd(burst[3]));
    @(posedge clk); #1;
`else
    // Back-to-back reads: arready low for STALL_CYC cycles after each handshake.
    idle(4);
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_ar_ready", arready, 1);
      @(posedge clk); #1;
      repeat (2) begin
        @(negedge clk);
        chk("stall_ar_low", arready, 0);
        @(posedge clk); #1;
      end
    end
    arvalid = 1'b0;
    @(negedge clk);
    chk("stall_ar_release", arready, 1);
    @(posedge clk); #1;
`endif

    // Same-edge write and read of one word return the old contents.
    idle(4);
    old_w = ref_rd(32'h10);
    awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rbw_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("rbw_bvalid", bvalid, 1);
    chk("rbw_rvalid", rvalid, 1);
    chk("rbw_old_data", rdata, old_w);
    ref_wr(32'h10, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    axi_read(32'h10);

    // Reset in the middle of a read burst with a W beat held.
    idle(4);
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    araddr = 32'h14;
    @(negedge clk);
    chk("midrst_rvalid_before", rvalid, 1);
    rst = 1'b1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_wready", wready, 1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_no_b", bvalid, 0);
      chk("postrst_no_r", rvalid, 0);
    end
    @(posedge clk); #1;
    axi_read(32'h10);

    // Random traffic over a small window plus out-of-range words.
    for (int t = 0; t < 60; t++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 19);
      a = (r < 16 ? r : 1024 + r) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      else axi_read(a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
